// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM state encoding
// and the requester identifier.
package dmem_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the requester named by the priority pointer.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    pointer,
  output logic [1:0] winner,
  output req_id_t    winner_id
);

  always_comb begin
    winner_id = pointer;
    if (req == 2'b01) begin
      winner_id = 1'b0;
    end else if (req == 2'b10) begin
      winner_id = 1'b1;
    end
    winner = '0;
    if (req != 2'b00) begin
      winner[winner_id] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core LSU (port 0) and debug/DMA (port 1) onto a single
// dmem bus; each access takes IDLE -> ACCESS -> RESP, three cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  input  logic [3:0]       r0_byteen,
  output logic             r0_gnt,
  output logic             r0_rsp_valid,
  output logic [WIDTH-1:0] r0_rdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  input  logic [3:0]       r1_byteen,
  output logic             r1_gnt,
  output logic             r1_rsp_valid,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_byteen,
  input  logic [WIDTH-1:0] mem_rdata
);

  logic [1:0]       req_vec;
  logic             req_we     [NUM_REQ];
  logic [WIDTH-1:0] req_addr   [NUM_REQ];
  logic [WIDTH-1:0] req_wdata  [NUM_REQ];
  logic [3:0]       req_byteen [NUM_REQ];

  assign req_vec       = {r1_req, r0_req};
  assign req_we[0]     = r0_we;
  assign req_we[1]     = r1_we;
  assign req_addr[0]   = r0_addr;
  assign req_addr[1]   = r1_addr;
  assign req_wdata[0]  = r0_wdata;
  assign req_wdata[1]  = r1_wdata;
  assign req_byteen[0] = r0_byteen;
  assign req_byteen[1] = r1_byteen;

  state_t           state_reg;
  req_id_t          ptr_reg;
  req_id_t          lat_id_reg;
  logic             lat_we_reg;
  logic [WIDTH-1:0] lat_addr_reg;
  logic [WIDTH-1:0] lat_wdata_reg;
  logic [3:0]       lat_byteen_reg;
  logic [1:0]       gnt_reg;
  logic [1:0]       rsp_valid_reg;
  logic [WIDTH-1:0] rdata_reg;

  logic [1:0] winner;
  req_id_t    winner_id;

  rr_arbiter2 u_rr (
    .req       (req_vec),
    .pointer   (ptr_reg),
    .winner    (winner),
    .winner_id (winner_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= 1'b0;
      lat_id_reg     <= 1'b0;
      lat_we_reg     <= 1'b0;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
      lat_byteen_reg <= '0;
      gnt_reg        <= '0;
      rsp_valid_reg  <= '0;
      rdata_reg      <= '0;
    end else begin
      gnt_reg       <= '0;
      rsp_valid_reg <= '0;
      rdata_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (req_vec != 2'b00) begin
            state_reg      <= ACCESS;
            lat_id_reg     <= winner_id;
            lat_we_reg     <= req_we[winner_id];
            lat_addr_reg   <= req_addr[winner_id];
            lat_wdata_reg  <= req_wdata[winner_id];
            lat_byteen_reg <= req_byteen[winner_id];
            gnt_reg        <= winner;
          end
        end
        ACCESS: begin
          state_reg                 <= RESP;
          rsp_valid_reg[lat_id_reg] <= 1'b1;
          // Stores report zero data so the response carries no stale bus value.
          rdata_reg                 <= lat_we_reg ? '0 : mem_rdata;
        end
        RESP: begin
          state_reg <= IDLE;
          ptr_reg   <= ~lat_id_reg;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic in_access;
  assign in_access  = (state_reg == ACCESS);
  assign mem_read   = in_access & ~lat_we_reg;
  assign mem_write  = in_access & lat_we_reg;
  assign mem_addr   = in_access ? lat_addr_reg : '0;
  assign mem_wdata  = in_access ? lat_wdata_reg : '0;
  assign mem_byteen = in_access ? lat_byteen_reg : 4'b0000;

  logic [WIDTH-1:0] rsp_rdata [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_rdata[gi] = rsp_valid_reg[gi] ? rdata_reg : '0;
  end

  assign r0_gnt       = gnt_reg[0];
  assign r1_gnt       = gnt_reg[1];
  assign r0_rsp_valid = rsp_valid_reg[0];
  assign r1_rsp_valid = rsp_valid_reg[1];
  assign r0_rdata     = rsp_rdata[0];
  assign r1_rdata     = rsp_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants and responses are queued
// with their cycle numbers as stimulus is driven and matched every cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_byteen, r1_byteen;
  logic        r0_gnt, r0_rsp_valid, r1_gnt, r1_rsp_valid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];

  dmem_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_byteen(r0_byteen), .r0_gnt(r0_gnt), .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_byteen(r1_byteen), .r1_gnt(r1_gnt), .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          id;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] rdata;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0]  exp_gnt, exp_rsp;
      logic [69:0] exp_mem;
      logic [31:0] exp_rd0, exp_rd1;
      exp_gnt = '0; exp_rsp = '0; exp_mem = '0; exp_rd0 = '0; exp_rd1 = '0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        gnt_t g;
        g = gq.pop_front();
        exp_gnt[g.id] = 1'b1;
        exp_mem = {~g.we, g.we, g.be, g.addr, g.wdata};
        $display("cyc %0d gnt r%0d we=%0d be=%b addr=%h wdata=%h", cyc, g.id, g.we, g.be, g.addr, g.wdata);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rsp_t r;
        r = rq.pop_front();
        exp_rsp[r.id] = 1'b1;
        if (r.id == 0) exp_rd0 = r.rdata; else exp_rd1 = r.rdata;
        $display("cyc %0d rsp r%0d rdata=%h", cyc, r.id, r.rdata);
      end
      chk("gnt", 128'({r1_gnt, r0_gnt}), 128'(exp_gnt));
      chk("mem_bus", 128'({mem_read, mem_write, mem_byteen, mem_addr, mem_wdata}), 128'(exp_mem));
      chk("rsp_valid", 128'({r1_rsp_valid, r0_rsp_valid}), 128'(exp_rsp));
      chk("r0_rdata", 128'(r0_rdata), 128'(exp_rd0));
      chk("r1_rdata", 128'(r1_rdata), 128'(exp_rd1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      r0_req = req; r0_we = we; r0_byteen = be; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_byteen = be; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  // Queue the grant expected at t+1 and, unless aborted, the response at t+2.
  task automatic push_acc(input int id, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int t, input bit with_rsp);
    gnt_t g;
    rsp_t r;
    g.cyc = t + 1; g.id = id; g.we = we; g.be = be; g.addr = addr; g.wdata = wd;
    gq.push_back(g);
    if (with_rsp) begin
      r.cyc = t + 2; r.id = id;
      r.rdata = we ? 32'h0 : mem[addr[9:2]];
      rq.push_back(r);
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
    mem[8'h40] = 32'hDEAD_BEEF;
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Simultaneous requests with pointer at 0: r0 first, r1 three cycles later.
    t = cyc;
    drive(0, 1, 0, 4'hF, 32'h100, 32'h0);
    drive(1, 1, 0, 4'hF, 32'h204, 32'h0);
    push_acc(0, 0, 4'hF, 32'h100, 32'h0, t, 1);
    push_acc(1, 0, 4'hF, 32'h204, 32'h0, t + 3, 1);
    tick(); drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick(); tick(); drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick();

    // Lone r1 store while the pointer favours r0.
    t = cyc;
    drive(1, 1, 1, 4'b0001, 32'h203, 32'h0000_00AB);
    push_acc(1, 1, 4'b0001, 32'h203, 32'h0000_00AB, t, 1);
    tick(); drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick();

    // Single load of 0xDEADBEEF by r0.
    t = cyc;
    drive(0, 1, 0, 4'hF, 32'h100, 32'h0);
    push_acc(0, 0, 4'hF, 32'h100, 32'h0, t, 1);
    tick(); drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick();

    // Fields change after latching; the bus must keep the latched address.
    t = cyc;
    drive(0, 1, 0, 4'hF, 32'h10, 32'h0);
    push_acc(0, 0, 4'hF, 32'h10, 32'h0, t, 1);
    tick(); drive(0, 1, 1, 4'h3, 32'h20, 32'h1234);
    tick(); drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    // Request pulse that never reaches a sampling edge.
    drive(1, 1, 0, 4'hF, 32'h44, 32'h0);
    @(negedge clk);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    // Reset during ACCESS of an r1 load, then a tie must go to r0.
    t = cyc;
    drive(1, 1, 0, 4'hF, 32'h104, 32'h0);
    push_acc(1, 0, 4'hF, 32'h104, 32'h0, t, 0);
    tick(); drive(1, 0, 0, 4'h0, 32'h0, 32'h0); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    t = cyc;
    drive(0, 1, 0, 4'hF, 32'h100, 32'h0);
    drive(1, 1, 0, 4'hF, 32'h204, 32'h0);
    push_acc(0, 0, 4'hF, 32'h100, 32'h0, t, 1);
    push_acc(1, 0, 4'hF, 32'h204, 32'h0, t + 3, 1);
    tick(); drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick(); tick(); drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    tick(); tick();

    // Fairness: both held for six accesses from a fresh reset.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    t = cyc;
    drive(0, 1, 0, 4'hF, 32'h300, 32'h0);
    drive(1, 1, 1, 4'hF, 32'h308, 32'h55AA_33CC);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_acc(0, 0, 4'hF, 32'h300, 32'h0, t + 3 * k, 1);
      else            push_acc(1, 1, 4'hF, 32'h308, 32'h55AA_33CC, t + 3 * k, 1);
    end
    repeat (16) tick();
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (6) tick();

    chk("gnt_pending", 128'(gq.size()), 128'(0));
    chk("rsp_pending", 128'(rq.size()), 128'(0));
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
